// File: rtl/duck_hunt_pkg.sv
// duck_hunt_pkg: screen geometry, colour constants and pixel addressing
// shared by the plot-side blocks of duck_hunt.
`default_nettype none

package duck_hunt_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int COLOUR_BITS = 3;
  localparam int ADDR_BITS   = 15;

  localparam logic [COLOUR_BITS-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_BITS-1:0] WHITE = 3'b111;
  localparam logic [COLOUR_BITS-1:0] BLUE  = 3'b001;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } sweep_state_t;

  // y*160 + x as shifts so it maps onto adders, not a multiplier
  function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [7:0] px,
                                                      input logic [6:0] py);
    return ({8'd0, py} << 7) + ({8'd0, py} << 5) + {7'd0, px};
  endfunction

endpackage

`default_nettype wire

// File: rtl/shadow_ram.sv
// shadow_ram: simple dual-port frame store, one write port and one
// synchronous read port that returns the pre-write value on collisions.
`default_nettype none

module shadow_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/plot_shadow_buffer.sv
// plot_shadow_buffer: mirrors the sprite plot stream into a shadow frame
// buffer and answers 2-cycle pixel read-back queries. Rev 1.0
`default_nettype none

module plot_shadow_buffer #(
  parameter int WIDTH       = duck_hunt_pkg::SCREEN_W,
  parameter int HEIGHT      = duck_hunt_pkg::SCREEN_H,
  parameter int COLOUR_BITS = duck_hunt_pkg::COLOUR_BITS,
  parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = duck_hunt_pkg::BLACK
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   plot,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   query_req,
  input  logic [7:0]             query_x,
  input  logic [6:0]             query_y,
  output logic                   query_valid,
  output logic [COLOUR_BITS-1:0] query_colour,
  output logic                   query_hit,
  output logic                   query_oob,
  output logic [15:0]            drop_count
);

  import duck_hunt_pkg::*;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);

  sweep_state_t state_q, state_d;
  logic [ADDR_BITS-1:0]   sweep_addr_q, sweep_addr_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_oob_q, s1_oob_d;
  logic                   query_valid_q, query_valid_d;
  logic                   query_oob_q, query_oob_d;
  logic                   query_hit_q, query_hit_d;
  logic [COLOUR_BITS-1:0] query_colour_q, query_colour_d;

  logic                   plot_in_range, query_in_range;
  logic                   ram_we, ram_re;
  logic [ADDR_BITS-1:0]   ram_waddr;
  logic [COLOUR_BITS-1:0] ram_wdata, ram_rdata;
  logic [15:0]            drop_inc;

  assign plot_in_range  = (x < 8'(WIDTH)) && (y < 7'(HEIGHT));
  assign query_in_range = (query_x < 8'(WIDTH)) && (query_y < 7'(HEIGHT));
  assign ram_re         = query_req && query_in_range;
  assign drop_inc       = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    sweep_addr_d   = sweep_addr_q;
    drop_count_d   = drop_count_q;
    ram_we         = 1'b0;
    ram_waddr      = pixel_addr(x, y);
    ram_wdata      = colour;
    s1_valid_d     = query_req;
    s1_oob_d       = !query_in_range;
    query_valid_d  = s1_valid_q;
    query_oob_d    = query_oob_q;
    query_hit_d    = query_hit_q;
    query_colour_d = query_colour_q;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_addr_q;
        ram_wdata = CLEAR_COLOUR;
        if (sweep_addr_q == LAST_ADDR) begin
          state_d      = ST_IDLE;
          sweep_addr_d = '0;
        end else begin
          sweep_addr_d = sweep_addr_q + 1'b1;
        end
        if (plot) drop_count_d = drop_inc;
      end
      ST_IDLE: begin
        // clear wins over a same-cycle plot, which is discarded uncounted
        if (clear_req) begin
          state_d      = ST_CLEAR;
          sweep_addr_d = '0;
          drop_count_d = '0;
        end else if (plot) begin
          if (plot_in_range) ram_we = 1'b1;
          else               drop_count_d = drop_inc;
        end
      end
    endcase

    if (s1_valid_q) begin
      query_oob_d    = s1_oob_q;
      query_colour_d = s1_oob_q ? CLEAR_COLOUR : ram_rdata;
      query_hit_d    = !s1_oob_q && (ram_rdata != CLEAR_COLOUR);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= ST_CLEAR;
      sweep_addr_q   <= '0;
      drop_count_q   <= '0;
      s1_valid_q     <= 1'b0;
      s1_oob_q       <= 1'b0;
      query_valid_q  <= 1'b0;
      query_oob_q    <= 1'b0;
      query_hit_q    <= 1'b0;
      query_colour_q <= '0;
    end else begin
      state_q        <= state_d;
      sweep_addr_q   <= sweep_addr_d;
      drop_count_q   <= drop_count_d;
      s1_valid_q     <= s1_valid_d;
      s1_oob_q       <= s1_oob_d;
      query_valid_q  <= query_valid_d;
      query_oob_q    <= query_oob_d;
      query_hit_q    <= query_hit_d;
      query_colour_q <= query_colour_d;
    end
  end

  shadow_ram #(
    .DEPTH(WIDTH * HEIGHT),
    .AW   (ADDR_BITS),
    .DW   (COLOUR_BITS)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(pixel_addr(query_x, query_y)),
    .rdata(ram_rdata)
  );

  assign clear_busy   = (state_q == ST_CLEAR);
  assign query_valid  = query_valid_q;
  assign query_colour = query_colour_q;
  assign query_hit    = query_hit_q;
  assign query_oob    = query_oob_q;
  assign drop_count   = drop_count_q;

endmodule

`default_nettype wire
